lc3_mem_ctrl: RTL and testbench
===============================

# lc3_mem_ctrl

CPU-side memory access controller for the LC-3 datapath; the initiator for the single-port RAM's CS/WE/ready interface. It takes one read or write request at a time from the control FSM and latches the address into an internal MAR. It drives the RAM strobes, waits for the RAM's ready on reads, captures read data into an internal MDR, and reports completion with a one-cycle DONE pulse. The block sits between the control unit and the RAM, replacing ad-hoc MAR/MDR/R handling in the top level.

## Interface
- WR_CYCLES, 2: cycles CS and WE are held for a write (1..15).
- TIMEOUT, 15: maximum RD_WAIT cycles without ready before the read is aborted (1..255).
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  reset; synchronous, active-high.
- REQ  in  1  request strobe; sampled only in IDLE.
- RW  in  1  request type: 0 = read, 1 = write.
- ADDR_IN  in  16  request address.
- DATA_IN  in  16  write data.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  read timeout flag; sticky until the next accepted REQ.
- MDR_OUT  out  16  MDR contents: read data, or write data during a write.
- MEM_ADDR  out  16  MAR contents.
- MEM_DATA  out  16  MDR contents.
- MEM_CS  out  1  RAM chip select.
- MEM_WE  out  1  RAM write enable.
- MEM_READY  in  1  RAM read-data-valid.
- MEM_RDATA  in  16  RAM read data.

## Operation
- States: IDLE, RD_SETUP, RD_WAIT, WR, DONE.
- IDLE, REQ=1:
  - Latch ADDR_IN into MAR and RW into an internal latch.
  - If RW=1, latch DATA_IN into MDR.
  - Clear ERR.
  - Next state: RD_SETUP if RW=0, WR if RW=1.
- IDLE, REQ=0: stay in IDLE; MAR and MDR hold their values.
- RD_SETUP:
  - MEM_CS=1, MEM_WE=0.
  - MEM_READY is ignored, because the RAM's ready is stale from the previous access.
  - Lasts one cycle, then RD_WAIT with the counter cleared.
- RD_WAIT:
  - MEM_CS=1, MEM_WE=0.
  - If MEM_READY=1: MDR <= MEM_RDATA, next state DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT: ERR <= 1, MDR is unchanged, next state DONE.
- WR:
  - MEM_CS=1, MEM_WE=1, MEM_DATA=MDR, MEM_ADDR=MAR.
  - Counter counts 0..WR_CYCLES-1, then DONE. MEM_READY is ignored.
- DONE: DONE=1, MEM_CS=0, MEM_WE=0; next state IDLE unconditionally.
- MEM_WE is never 1 while MEM_CS=0. MEM_WE=1 only in WR.
- REQ outside IDLE is ignored and not queued. REQ asserted in the DONE cycle is also ignored; the control FSM must re-assert it in IDLE.
- MAR and MDR are stable for the entire access. ADDR_IN and DATA_IN may change freely after acceptance.
- Counter is 8 bits, cleared on every state entry; no wrap, because the exits occur before overflow.

## Timing
- Reset values: state IDLE, MAR=0, MDR=0, counter 0, BUSY=0, DONE=0, ERR=0, MEM_CS=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, MDR_OUT=0.
- RST asserted mid-access: the next edge returns to IDLE with all reset values. MEM_CS drops that cycle, no DONE is emitted, and MDR is cleared.
- All outputs are registered or decoded from state only; there is no combinational path from REQ or MEM_READY to any output.
- Read latency, REQ sampled at edge 0:
  - RD_SETUP in cycle 1.
  - RD_WAIT from cycle 2; if ready is seen in cycle 2, DONE is high in cycle 3.
  - Minimum read latency is 3 cycles.
- Read timeout: DONE is high in cycle 2+TIMEOUT, with ERR=1 in that same cycle.
- Write latency: WR during cycles 1..WR_CYCLES; DONE in cycle WR_CYCLES+1.
- Back-to-back: the earliest next REQ acceptance is at the edge ending the first IDLE cycle after DONE. Throughput is at most one access per 4 cycles for reads and WR_CYCLES+2 cycles for writes.

## Structure
- Package lc3_mem_pkg:
  - State enum.
  - Constants MEM_RD=1'b0 and MEM_WR=1'b1.
  - Default WR_CYCLES and TIMEOUT values.
- One natural sub-module, mem_cycle_counter: 8-bit counter with synchronous clear, enable, and a terminal-count compare against a runtime limit. It serves both the write hold and the read timeout.
- MAR and MDR are local registers with synchronous reset.

## Test plan
- Read hit: RAM model asserts ready in the first RD_WAIT cycle. REQ, RW=0, ADDR_IN=16'h0007 with memory[7]=16'h0005 -> MEM_CS high in cycles 1-2, DONE in cycle 3, MDR_OUT=16'h0005, ERR=0.
- Write: REQ, RW=1, ADDR_IN=16'h0010, DATA_IN=16'hBEEF, WR_CYCLES=2 -> MEM_CS=MEM_WE=1 for exactly cycles 1-2, DONE in cycle 3. A subsequent read of 16'h0010 returns 16'hBEEF.
- Stale ready: ready held high from the previous read; RAM model delays new data by 3 cycles -> MDR captures the new data, not the old data, and is not captured in RD_SETUP.
- Timeout: ready held low, TIMEOUT=4 -> DONE in cycle 6 with ERR=1 and MDR unchanged. The next accepted REQ clears ERR.
- REQ during busy: pulse REQ with a different address in cycle 2 of a read -> ignored; MEM_ADDR is unchanged and only one DONE pulse occurs.
- Reset mid-write: assert RST in cycle 1 of WR -> next cycle MEM_CS=0, MEM_WE=0, BUSY=0, MAR=MDR=0, no DONE pulse.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
package lc3_mem_pkg;

    // Controller FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_SETUP = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4
    } mem_state_e;

    // Request type encoding on RW.
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Default write hold length and read timeout, in cycles.
    localparam int DEF_WR_CYCLES = 2;
    localparam int DEF_TIMEOUT   = 15;

    // Width of the shared cycle counter.
    localparam int CNT_W = 8;

    // States in which the RAM is selected.
    function automatic logic drives_cs(input mem_state_e st);
        return (st == ST_RD_SETUP) || (st == ST_RD_WAIT) || (st == ST_WR);
    endfunction

endpackage

// File: rtl/mem_cycle_counter.sv
// Cycle counter with synchronous clear, enable and a terminal-count flag
// that fires on the last cycle of a window of limit_i cycles.
module mem_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over enable; no wrap handling because
    // the owning FSM always leaves the counting state before overflow.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count: the current cycle is the limit_i-th cycle of the window.
    assign tc_o = (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 CPU-side memory access controller: owns MAR/MDR, sequences the
// RAM CS/WE strobes, waits for ready on reads with a timeout, and pulses
// DONE for one cycle when an access completes.
//
// Handshake: REQ is only looked at while BUSY=0 (IDLE); a request seen
// there is accepted on that edge and BUSY rises the next cycle. REQ at
// any other time, including the DONE cycle, is dropped, not queued. On
// the RAM side, CS (and WE for writes) is held for the whole access and
// MEM_READY is a read-data-valid qualifier sampled only in RD_WAIT.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WR_CYCLES = DEF_WR_CYCLES,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        RW,
    input  logic [15:0] ADDR_IN,
    input  logic [15:0] DATA_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] MDR_OUT,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_DATA,
    output logic        MEM_CS,
    output logic        MEM_WE,
    input  logic        MEM_READY,
    input  logic [15:0] MEM_RDATA,
    output logic [2:0]  STATE_DBG
);

    mem_state_e  state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        rw_q, rw_d;
    logic        err_q, err_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    // The latched request type picks the window: write hold or read timeout.
    assign cnt_limit = (rw_q == MEM_WR) ? CNT_W'(WR_CYCLES) : CNT_W'(TIMEOUT);

    // Counter restarts on every state entry and runs only while waiting.
    assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE);
    assign cnt_en  = (state_q == ST_RD_WAIT) || (state_q == ST_WR);

    mem_cycle_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    // Next-state and register-update logic for the access sequence.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rw_d    = rw_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    mar_d = ADDR_IN;
                    rw_d  = RW;
                    err_d = 1'b0;
                    if (RW == MEM_WR) begin
                        mdr_d   = DATA_IN;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_SETUP;
                    end
                end
            end
            ST_RD_SETUP: begin
                // Ready still reflects the previous access here; ignore it.
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (MEM_READY) begin
                    mdr_d   = MEM_RDATA;
                    state_d = ST_DONE;
                end else if (cnt_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                if (cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        BUSY   = (state_q != ST_IDLE);
        DONE   = (state_q == ST_DONE);
        MEM_CS = drives_cs(state_q);
        MEM_WE = (state_q == ST_WR);
    end

    // State, MAR, MDR, request type and sticky error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= MEM_RD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
        end
    end

    assign ERR       = err_q;
    assign MDR_OUT   = mdr_q;
    assign MEM_ADDR  = mar_q;
    assign MEM_DATA  = mdr_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed testbench for lc3_mem_ctrl with a small behavioural RAM.
module tb_lc3_mem_ctrl;
    import lc3_mem_pkg::*;

    localparam int WRC = 2;
    localparam int TMO = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic        RW  = 1'b0;
    logic [15:0] ADDR_IN = '0;
    logic [15:0] DATA_IN = '0;
    logic        BUSY, DONE, ERR, MEM_CS, MEM_WE;
    logic [15:0] MDR_OUT, MEM_ADDR, MEM_DATA;
    logic        MEM_READY = 1'b0;
    logic [15:0] MEM_RDATA = '0;
    logic [2:0]  STATE_DBG;

    always #5 CLK = ~CLK;

    lc3_mem_ctrl #(
        .WR_CYCLES (WRC),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .RW        (RW),
        .ADDR_IN   (ADDR_IN),
        .DATA_IN   (DATA_IN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .MDR_OUT   (MDR_OUT),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DATA  (MEM_DATA),
        .MEM_CS    (MEM_CS),
        .MEM_WE    (MEM_WE),
        .MEM_READY (MEM_READY),
        .MEM_RDATA (MEM_RDATA),
        .STATE_DBG (STATE_DBG)
    );

    // ---------------- RAM model ----------------
    // Reads: ready rises after rd_lat CS cycles; ram_stall keeps it low;
    // hold_ready leaves the last ready/data on the bus after CS drops.
    logic [15:0] mem [0:255];
    int          rd_lat     = 1;
    bit          ram_stall  = 1'b0;
    bit          hold_ready = 1'b0;
    int          cs_cnt     = 0;

    always @(posedge CLK) begin
        if (MEM_CS && MEM_WE) mem[MEM_ADDR[7:0]] <= MEM_DATA;
        if (MEM_CS && !MEM_WE) begin
            cs_cnt <= cs_cnt + 1;
            if (!ram_stall && (cs_cnt + 1 >= rd_lat)) begin
                MEM_READY <= 1'b1;
                MEM_RDATA <= mem[MEM_ADDR[7:0]];
            end else begin
                MEM_READY <= 1'b0;
            end
        end else begin
            cs_cnt <= 0;
            if (!hold_ready) MEM_READY <= 1'b0;
        end
    end

    // ---------------- recording / counters ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic        rec_cs   [0:15];
    logic        rec_we   [0:15];
    logic        rec_done [0:15];
    logic        rec_busy [0:15];
    logic        rec_err  [0:15];
    logic [15:0] rec_addr [0:15];
    logic [15:0] rec_mdr  [0:15];
    logic [15:0] rec_data [0:15];
    logic [2:0]  rec_st   [0:15];
    logic [15:0] e_cs, e_we, e_done, e_busy;

    // ---------------- driver ----------------
    // Cycle 0 is the IDLE cycle whose closing edge samples the first REQ.
    // REQ is high in cycle c when req_mask[c]; RST is high in cycle rst_cyc.
    // Outputs are recorded at each negedge for cycles 0..ncyc.
    task automatic run_access(input logic rw, input logic [15:0] a1, input logic [15:0] d1,
                              input logic [15:0] a2, input logic [15:0] req_mask,
                              input int rst_cyc, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge CLK);
            rec_cs[c]   = MEM_CS;
            rec_we[c]   = MEM_WE;
            rec_done[c] = DONE;
            rec_busy[c] = BUSY;
            rec_err[c]  = ERR;
            rec_addr[c] = MEM_ADDR;
            rec_mdr[c]  = MDR_OUT;
            rec_data[c] = MEM_DATA;
            rec_st[c]   = STATE_DBG;
            REQ     = req_mask[c];
            RW      = rw;
            ADDR_IN = (c == 0) ? a1 : (req_mask[c] ? a2 : 16'hDEAD);
            DATA_IN = (c == 0) ? d1 : 16'h5A5A;
            RST     = (c == rst_cyc);
        end
        REQ = 1'b0;
        RST = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        ADDR_IN = 16'hFFFF;
        DATA_IN = 16'hFFFF;
        repeat (3) @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", DONE); end
        n_cmp++; if (ERR !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", ERR); end
        n_cmp++; if (MEM_CS !== 1'b0 || MEM_WE !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got cs=%b we=%b expected 0 0", MEM_CS, MEM_WE); end
        n_cmp++; if (MEM_ADDR !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", MEM_ADDR); end
        n_cmp++; if (MEM_DATA !== 16'h0 || MDR_OUT !== 16'h0) begin n_err++; $display("FAIL reset_mdr: got data=%h mdr=%h expected 0000", MEM_DATA, MDR_OUT); end
        n_cmp++; if (STATE_DBG !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", STATE_DBG, ST_IDLE); end
        RST = 1'b0;
    endtask

    task automatic test_read_hit();
        rd_lat = 1; ram_stall = 1'b0; hold_ready = 1'b0;
        run_access(MEM_RD, 16'h0007, 16'h0000, 16'h0000, 16'h0001, -1, 4);
        e_cs = 16'b00110; e_we = 16'b00000; e_done = 16'b01000; e_busy = 16'b01110;
        for (int c = 0; c <= 4; c++) begin
            n_cmp++; if (rec_cs[c] !== e_cs[c]) begin n_err++; $display("FAIL rd_hit_cs[%0d]: got %b expected %b", c, rec_cs[c], e_cs[c]); end
            n_cmp++; if (rec_we[c] !== e_we[c]) begin n_err++; $display("FAIL rd_hit_we[%0d]: got %b expected %b", c, rec_we[c], e_we[c]); end
            n_cmp++; if (rec_done[c] !== e_done[c]) begin n_err++; $display("FAIL rd_hit_done[%0d]: got %b expected %b", c, rec_done[c], e_done[c]); end
            n_cmp++; if (rec_busy[c] !== e_busy[c]) begin n_err++; $display("FAIL rd_hit_busy[%0d]: got %b expected %b", c, rec_busy[c], e_busy[c]); end
        end
        n_cmp++; if (rec_addr[2] !== 16'h0007) begin n_err++; $display("FAIL rd_hit_addr: got %h expected 0007", rec_addr[2]); end
        n_cmp++; if (rec_mdr[2] !== 16'h0000) begin n_err++; $display("FAIL rd_hit_mdr_early: got %h expected 0000", rec_mdr[2]); end
        n_cmp++; if (rec_mdr[3] !== 16'h0005) begin n_err++; $display("FAIL rd_hit_mdr: got %h expected 0005", rec_mdr[3]); end
        n_cmp++; if (rec_err[3] !== 1'b0) begin n_err++; $display("FAIL rd_hit_err: got %b expected 0", rec_err[3]); end
    endtask

    task automatic test_write();
        run_access(MEM_WR, 16'h0010, 16'hBEEF, 16'h0000, 16'h0001, -1, 4);
        e_cs = 16'b00110; e_we = 16'b00110; e_done = 16'b01000; e_busy = 16'b01110;
        for (int c = 0; c <= 4; c++) begin
            n_cmp++; if (rec_cs[c] !== e_cs[c]) begin n_err++; $display("FAIL wr_cs[%0d]: got %b expected %b", c, rec_cs[c], e_cs[c]); end
            n_cmp++; if (rec_we[c] !== e_we[c]) begin n_err++; $display("FAIL wr_we[%0d]: got %b expected %b", c, rec_we[c], e_we[c]); end
            n_cmp++; if (rec_done[c] !== e_done[c]) begin n_err++; $display("FAIL wr_done[%0d]: got %b expected %b", c, rec_done[c], e_done[c]); end
            n_cmp++; if (rec_busy[c] !== e_busy[c]) begin n_err++; $display("FAIL wr_busy[%0d]: got %b expected %b", c, rec_busy[c], e_busy[c]); end
        end
        for (int c = 1; c <= 2; c++) begin
            n_cmp++; if (rec_data[c] !== 16'hBEEF || rec_addr[c] !== 16'h0010) begin n_err++; $display("FAIL wr_bus[%0d]: got addr=%h data=%h expected 0010 beef", c, rec_addr[c], rec_data[c]); end
        end
        // Another write elsewhere, then read the first location back.
        run_access(MEM_WR, 16'h0011, 16'h1234, 16'h0000, 16'h0001, -1, 4);
        n_cmp++; if (rec_mdr[3] !== 16'h1234) begin n_err++; $display("FAIL wr2_mdr: got %h expected 1234", rec_mdr[3]); end
        rd_lat = 1;
        run_access(MEM_RD, 16'h0010, 16'h0000, 16'h0000, 16'h0001, -1, 4);
        n_cmp++; if (rec_mdr[3] !== 16'hBEEF) begin n_err++; $display("FAIL wr_readback: got %h expected beef", rec_mdr[3]); end
    endtask

    task automatic test_stale_ready();
        rd_lat = 1; hold_ready = 1'b1;
        run_access(MEM_RD, 16'h0020, 16'h0000, 16'h0000, 16'h0001, -1, 4);
        n_cmp++; if (rec_mdr[3] !== 16'h1020) begin n_err++; $display("FAIL stale_first_rd: got %h expected 1020", rec_mdr[3]); end
        // Ready stays high with 1020 through this write and the next RD_SETUP.
        run_access(MEM_WR, 16'h0030, 16'hC0DE, 16'h0000, 16'h0001, -1, 4);
        n_cmp++; if (rec_done[3] !== 1'b1) begin n_err++; $display("FAIL stale_wr_done: got %b expected 1", rec_done[3]); end
        rd_lat = 3;
        run_access(MEM_RD, 16'h0031, 16'h0000, 16'h0000, 16'h0001, -1, 6);
        hold_ready = 1'b0;
        n_cmp++; if (rec_mdr[2] !== 16'hC0DE) begin n_err++; $display("FAIL stale_setup_capture: got %h expected c0de", rec_mdr[2]); end
        n_cmp++; if (rec_mdr[4] !== 16'hC0DE) begin n_err++; $display("FAIL stale_wait_mdr: got %h expected c0de", rec_mdr[4]); end
        e_done = 16'b0100000; e_cs = 16'b0011110;
        for (int c = 0; c <= 6; c++) begin
            n_cmp++; if (rec_done[c] !== e_done[c]) begin n_err++; $display("FAIL stale_done[%0d]: got %b expected %b", c, rec_done[c], e_done[c]); end
            n_cmp++; if (rec_cs[c] !== e_cs[c]) begin n_err++; $display("FAIL stale_cs[%0d]: got %b expected %b", c, rec_cs[c], e_cs[c]); end
        end
        n_cmp++; if (rec_mdr[5] !== 16'h1031) begin n_err++; $display("FAIL stale_new_data: got %h expected 1031", rec_mdr[5]); end
    endtask

    task automatic test_timeout();
        ram_stall = 1'b1;
        run_access(MEM_RD, 16'h0040, 16'h0000, 16'h0000, 16'h0001, -1, 7);
        ram_stall = 1'b0;
        e_done = 16'b01000000; e_busy = 16'b01111110; e_cs = 16'b00111110;
        for (int c = 0; c <= 7; c++) begin
            n_cmp++; if (rec_done[c] !== e_done[c]) begin n_err++; $display("FAIL to_done[%0d]: got %b expected %b", c, rec_done[c], e_done[c]); end
            n_cmp++; if (rec_busy[c] !== e_busy[c]) begin n_err++; $display("FAIL to_busy[%0d]: got %b expected %b", c, rec_busy[c], e_busy[c]); end
            n_cmp++; if (rec_cs[c] !== e_cs[c]) begin n_err++; $display("FAIL to_cs[%0d]: got %b expected %b", c, rec_cs[c], e_cs[c]); end
        end
        n_cmp++; if (rec_err[5] !== 1'b0) begin n_err++; $display("FAIL to_err_early: got %b expected 0", rec_err[5]); end
        n_cmp++; if (rec_err[6] !== 1'b1) begin n_err++; $display("FAIL to_err: got %b expected 1", rec_err[6]); end
        n_cmp++; if (rec_err[7] !== 1'b1) begin n_err++; $display("FAIL to_err_sticky: got %b expected 1", rec_err[7]); end
        n_cmp++; if (rec_mdr[6] !== 16'h1031) begin n_err++; $display("FAIL to_mdr_kept: got %h expected 1031", rec_mdr[6]); end
        rd_lat = 1;
        run_access(MEM_RD, 16'h0007, 16'h0000, 16'h0000, 16'h0001, -1, 4);
        n_cmp++; if (rec_err[0] !== 1'b1) begin n_err++; $display("FAIL to_err_before_req: got %b expected 1", rec_err[0]); end
        n_cmp++; if (rec_err[1] !== 1'b0) begin n_err++; $display("FAIL to_err_cleared: got %b expected 0", rec_err[1]); end
        n_cmp++; if (rec_mdr[3] !== 16'h0005) begin n_err++; $display("FAIL to_next_read: got %h expected 0005", rec_mdr[3]); end
    endtask

    task automatic test_req_during_busy();
        rd_lat = 1;
        run_access(MEM_RD, 16'h0021, 16'h0000, 16'h0099, 16'b000101, -1, 5);
        e_done = 16'b001000; e_busy = 16'b001110;
        for (int c = 0; c <= 5; c++) begin
            n_cmp++; if (rec_done[c] !== e_done[c]) begin n_err++; $display("FAIL busy_req_done[%0d]: got %b expected %b", c, rec_done[c], e_done[c]); end
            n_cmp++; if (rec_busy[c] !== e_busy[c]) begin n_err++; $display("FAIL busy_req_busy[%0d]: got %b expected %b", c, rec_busy[c], e_busy[c]); end
        end
        for (int c = 1; c <= 5; c++) begin
            n_cmp++; if (rec_addr[c] !== 16'h0021) begin n_err++; $display("FAIL busy_req_addr[%0d]: got %h expected 0021", c, rec_addr[c]); end
        end
        n_cmp++; if (rec_mdr[3] !== 16'h1021) begin n_err++; $display("FAIL busy_req_mdr: got %h expected 1021", rec_mdr[3]); end
    endtask

    task automatic test_done_cycle_req();
        rd_lat = 1;
        run_access(MEM_RD, 16'h0022, 16'h0000, 16'h0099, 16'b001001, -1, 5);
        e_busy = 16'b001110;
        for (int c = 0; c <= 5; c++) begin
            n_cmp++; if (rec_busy[c] !== e_busy[c]) begin n_err++; $display("FAIL done_req_busy[%0d]: got %b expected %b", c, rec_busy[c], e_busy[c]); end
        end
        n_cmp++; if (rec_addr[5] !== 16'h0022) begin n_err++; $display("FAIL done_req_addr: got %h expected 0022", rec_addr[5]); end
    endtask

    task automatic test_back_to_back();
        rd_lat = 1;
        run_access(MEM_RD, 16'h0023, 16'h0000, 16'h0024, 16'b000010001, -1, 8);
        e_done = 16'h0088; e_busy = 16'h00EE; e_cs = 16'h0066;
        for (int c = 0; c <= 8; c++) begin
            n_cmp++; if (rec_done[c] !== e_done[c]) begin n_err++; $display("FAIL b2b_done[%0d]: got %b expected %b", c, rec_done[c], e_done[c]); end
            n_cmp++; if (rec_busy[c] !== e_busy[c]) begin n_err++; $display("FAIL b2b_busy[%0d]: got %b expected %b", c, rec_busy[c], e_busy[c]); end
            n_cmp++; if (rec_cs[c] !== e_cs[c]) begin n_err++; $display("FAIL b2b_cs[%0d]: got %b expected %b", c, rec_cs[c], e_cs[c]); end
        end
        n_cmp++; if (rec_mdr[3] !== 16'h1023) begin n_err++; $display("FAIL b2b_mdr1: got %h expected 1023", rec_mdr[3]); end
        n_cmp++; if (rec_addr[5] !== 16'h0024) begin n_err++; $display("FAIL b2b_addr2: got %h expected 0024", rec_addr[5]); end
        n_cmp++; if (rec_mdr[7] !== 16'h1024) begin n_err++; $display("FAIL b2b_mdr2: got %h expected 1024", rec_mdr[7]); end
    endtask

    task automatic test_reset_mid_write();
        run_access(MEM_WR, 16'h0050, 16'h7777, 16'h0000, 16'h0001, 1, 5);
        n_cmp++; if (rec_cs[1] !== 1'b1 || rec_we[1] !== 1'b1) begin n_err++; $display("FAIL rst_wr_active: got cs=%b we=%b expected 1 1", rec_cs[1], rec_we[1]); end
        n_cmp++; if (rec_cs[2] !== 1'b0 || rec_we[2] !== 1'b0) begin n_err++; $display("FAIL rst_wr_strobes: got cs=%b we=%b expected 0 0", rec_cs[2], rec_we[2]); end
        n_cmp++; if (rec_busy[2] !== 1'b0) begin n_err++; $display("FAIL rst_wr_busy: got %b expected 0", rec_busy[2]); end
        n_cmp++; if (rec_addr[2] !== 16'h0000) begin n_err++; $display("FAIL rst_wr_mar: got %h expected 0000", rec_addr[2]); end
        n_cmp++; if (rec_mdr[2] !== 16'h0000 || rec_data[2] !== 16'h0000) begin n_err++; $display("FAIL rst_wr_mdr: got mdr=%h data=%h expected 0000", rec_mdr[2], rec_data[2]); end
        n_cmp++; if (rec_st[2] !== ST_IDLE) begin n_err++; $display("FAIL rst_wr_state: got %0d expected %0d", rec_st[2], ST_IDLE); end
        for (int c = 0; c <= 5; c++) begin
            n_cmp++; if (rec_done[c] !== 1'b0) begin n_err++; $display("FAIL rst_wr_done[%0d]: got %b expected 0", c, rec_done[c]); end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[7] = 16'h0005;
        test_reset();
        test_read_hit();
        test_write();
        test_stale_ready();
        test_timeout();
        test_req_during_busy();
        test_done_cycle_req();
        test_back_to_back();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
